// File: rtl/histogram_loader.sv
// histogram_loader
// Reads a saved 1024-bin histogram (4 sectors x 256 bins, big-endian bins,
// bin 0 first) back from the SD card and writes it into the 16x1024
// reference-histogram BRAM. Runs in the 25 MHz SD clock domain and drives
// the sd_controller read handshake. Any wait state that exceeds TIMEOUT
// cycles aborts the load and raises a sticky error.
module histogram_loader #(
  parameter int SECTORS = 4,
  parameter int TIMEOUT = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  slot,
  input  logic        sd_ready,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  output logic [9:0]  haddr,
  output logic [15:0] hdata,
  output logic        hwe,
  output logic        loading,
  output logic        done,
  output logic        error
);

  localparam logic [1:0]  LAST_SECTOR = 2'(SECTORS - 1);
  localparam logic [31:0] TIMEOUT_W   = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_ISSUE    = 3'd2,
    S_READ     = 3'd3,
    S_SECT_END = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [3:0]  r_slot;
  logic [1:0]  r_sector;
  logic [8:0]  r_byte_idx;
  logic [7:0]  r_hi;
  logic        r_bav_d;
  logic [31:0] r_timer;

  logic        r_sd_rd;
  logic [31:0] r_sd_address;
  logic [9:0]  r_haddr;
  logic [15:0] r_hdata;
  logic        r_hwe;
  logic        r_loading;
  logic        r_done;
  logic        r_error;

  logic        w_bav_rise;
  logic        w_byte_acc;
  logic        w_last_byte;
  logic        w_waiting;
  logic        w_abort;
  logic        w_start_acc;
  logic        w_last_sector;

  // A byte is one rising edge of byte_available, however long the level is held.
  assign w_bav_rise    = sd_byte_available & ~r_bav_d;
  assign w_byte_acc    = (r_state == S_READ) & w_bav_rise;
  assign w_last_byte   = w_byte_acc & (r_byte_idx == 9'd511);
  assign w_waiting     = (r_state == S_WAIT_RDY) | (r_state == S_ISSUE) |
                         (r_state == S_READ)     | (r_state == S_SECT_END);
  // An accepted byte restarts the timer, so it wins over a simultaneous expiry.
  assign w_abort       = w_waiting & (r_timer >= TIMEOUT_W) & ~w_byte_acc;
  assign w_start_acc   = (r_state == S_IDLE) & start;
  assign w_last_sector = (r_sector == LAST_SECTOR);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: read handshake sequencing with timeout abort.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_WAIT_RDY;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT_RDY: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (sd_ready) begin
          w_next = S_ISSUE;
        end else begin
          w_next = S_WAIT_RDY;
        end
      end
      S_ISSUE: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (!sd_ready) begin
          w_next = S_READ;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_READ: begin
        if (w_last_byte) begin
          w_next = S_SECT_END;
        end else if (w_abort) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_READ;
        end
      end
      S_SECT_END: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (sd_ready && w_last_sector) begin
          w_next = S_DONE;
        end else if (sd_ready) begin
          w_next = S_ISSUE;
        end else begin
          w_next = S_SECT_END;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Previous byte_available level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bav_d <= 1'b0;
    end else begin
      r_bav_d <= sd_byte_available;
    end
  end

  // Wait-state timer: cleared on any state change or accepted byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= 32'd0;
    end else if ((w_next != r_state) || w_byte_acc || !w_waiting) begin
      r_timer <= 32'd0;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  // Load bookkeeping: slot, sector, byte index, SD request and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot       <= 4'd0;
      r_sector     <= 2'd0;
      r_byte_idx   <= 9'd0;
      r_hi         <= 8'd0;
      r_sd_rd      <= 1'b0;
      r_sd_address <= 32'd0;
      r_loading    <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      // Request stays up for exactly the ISSUE residency; drops on abort too.
      r_sd_rd <= (w_next == S_ISSUE);
      r_done  <= (r_state == S_SECT_END) && (w_next == S_DONE);
      if (w_start_acc) begin
        r_slot       <= slot;
        r_sector     <= 2'd0;
        r_byte_idx   <= 9'd0;
        r_error      <= 1'b0;
        r_loading    <= 1'b1;
        r_sd_address <= {17'd0, slot, 2'd0, 9'd0};
      end
      if (w_byte_acc) begin
        r_byte_idx <= r_byte_idx + 9'd1;
        if (!r_byte_idx[0]) begin
          r_hi <= sd_dout;
        end
      end
      // Address only moves between sectors, never while sd_rd is high.
      if ((r_state == S_SECT_END) && (w_next == S_ISSUE)) begin
        r_sector     <= r_sector + 2'd1;
        r_byte_idx   <= 9'd0;
        r_sd_address <= {17'd0, r_slot, r_sector + 2'd1, 9'd0};
      end
      if ((r_state == S_SECT_END) && (w_next == S_DONE)) begin
        r_loading <= 1'b0;
      end
      if (w_abort) begin
        r_error   <= 1'b1;
        r_loading <= 1'b0;
      end
    end
  end

  // BRAM write port: one write per completed (hi, lo) byte pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_haddr <= 10'd0;
      r_hdata <= 16'd0;
      r_hwe   <= 1'b0;
    end else begin
      r_hwe <= 1'b0;
      if (w_byte_acc && r_byte_idx[0]) begin
        r_hwe   <= 1'b1;
        r_haddr <= {r_sector, r_byte_idx[8:1]};
        r_hdata <= {r_hi, sd_dout};
      end
    end
  end

  assign sd_rd      = r_sd_rd;
  assign sd_address = r_sd_address;
  assign haddr      = r_haddr;
  assign hdata      = r_hdata;
  assign hwe        = r_hwe;
  assign loading    = r_loading;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_histogram_loader.sv
// tb_histogram_loader
// Randomized bench: a behavioural SD read controller feeds sector data and a
// monitor collects BRAM writes, read addresses and done pulses, which are
// compared against bins computed directly from the slot/byte-order rules.
module tb_histogram_loader;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  slot;
  logic        sd_ready;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout;
  logic        sd_byte_available;
  logic [9:0]  haddr;
  logic [15:0] hdata;
  logic        hwe;
  logic        loading;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // SD model controls
  int hold_cycles = 1;
  int data_mode   = 0;
  int stop_after  = -1;
  bit model_abort = 1'b0;
  int last_byte_cyc = 0;

  // Monitor results
  logic [25:0] wq[$];
  logic [31:0] aq[$];
  int done_cnt = 0;
  int addr_moved = 0;

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  histogram_loader #(.SECTORS(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .slot(slot),
    .sd_ready(sd_ready), .sd_rd(sd_rd), .sd_address(sd_address),
    .sd_dout(sd_dout), .sd_byte_available(sd_byte_available),
    .haddr(haddr), .hdata(hdata), .hwe(hwe),
    .loading(loading), .done(done), .error(error)
  );

  function automatic logic [7:0] byte_value(input int mode, input int sec, input int k);
    if (mode == 1) return (k % 2 == 0) ? 8'hAB : 8'hCD;
    return 8'((sec * 512 + k) & 255);
  endfunction

  function automatic logic [15:0] exp_bin(input int mode, input int b);
    int s;
    int j;
    s = b / 256;
    j = b % 256;
    return {byte_value(mode, s, 2 * j), byte_value(mode, s, 2 * j + 1)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural SD controller: answers each read request with 512 bytes.
  initial begin
    logic [31:0] m_addr;
    int m_sec;
    sd_ready = 1'b1;
    sd_byte_available = 1'b0;
    sd_dout = 8'd0;
    forever begin
      @(negedge clk);
      if (sd_rd === 1'b1 && !model_abort) begin
        m_addr = sd_address;
        m_sec = int'(m_addr[10:9]);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sd_ready = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        for (int k = 0; k < 512; k++) begin
          if (model_abort) break;
          if (stop_after >= 0 && k > stop_after) begin
            while (!model_abort) @(negedge clk);
            break;
          end
          sd_dout = byte_value(data_mode, m_sec, k);
          sd_byte_available = 1'b1;
          last_byte_cyc = cyc;
          repeat (hold_cycles) @(negedge clk);
          sd_byte_available = 1'b0;
          repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        sd_byte_available = 1'b0;
        repeat (2) @(negedge clk);
        sd_ready = 1'b1;
      end
    end
  end

  // Monitor: BRAM writes, read-request addresses, done pulses, address stability.
  initial begin
    logic prev_rd;
    logic [31:0] prev_addr;
    prev_rd = 1'b0;
    prev_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (hwe) wq.push_back({haddr, hdata});
        if (done) done_cnt++;
        if (sd_rd && !prev_rd) aq.push_back(sd_address);
        if (sd_rd && prev_rd && (sd_address != prev_addr)) addr_moved++;
      end
      prev_rd = sd_rd;
      prev_addr = sd_address;
    end
  end

  task automatic start_load(input logic [3:0] s);
    @(negedge clk);
    wq.delete();
    aq.delete();
    done_cnt = 0;
    addr_moved = 0;
    slot = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    slot = 4'($urandom);
    check("loading_rise", 32'(loading), 32'd1);
  endtask

  task automatic wait_end(output int res, output int end_cyc);
    res = 2;
    end_cyc = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done) begin
        check("loading_at_done", 32'(loading), 32'd0);
        res = 0;
        end_cyc = cyc;
        break;
      end
      if (error && !loading) begin
        res = 1;
        end_cyc = cyc;
        break;
      end
    end
    if (res == 2) check("load_bound", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_writes(input int n);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (wq.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("writes_bound", 32'd0, 32'd1);
  endtask

  task automatic verify_ok(input int s, input int mode);
    check("wr_count", 32'(wq.size()), 32'd1024);
    for (int i = 0; i < wq.size() && i < 1024; i++) begin
      check("haddr", 32'(wq[i][25:16]), 32'(i));
      check("hdata", 32'(wq[i][15:0]), 32'(exp_bin(mode, i)));
    end
    check("rd_count", 32'(aq.size()), 32'd4);
    for (int i = 0; i < aq.size() && i < 4; i++)
      check("sd_addr", aq[i], 32'(s * 2048 + i * 512));
    check("done_count", 32'(done_cnt), 32'd1);
    check("addr_stable", 32'(addr_moved), 32'd0);
    check("error_clear", 32'(error), 32'd0);
    check("loading_low", 32'(loading), 32'd0);
  endtask

  initial begin
    int res;
    int ec;
    int cnt[4];
    logic [3:0] s;
    reset_n = 1'b0;
    start = 1'b0;
    slot = 4'd0;
    repeat (4) @(negedge clk);
    check("rst_sd_rd", 32'(sd_rd), 32'd0);
    check("rst_sd_address", sd_address, 32'd0);
    check("rst_haddr", 32'(haddr), 32'd0);
    check("rst_hdata", 32'(hdata), 32'd0);
    check("rst_hwe", 32'(hwe), 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal load of slot 3
    hold_cycles = 1;
    data_mode = 0;
    start_load(4'd3);
    wait_end(res, ec);
    check("nominal_res", 32'(res), 32'd0);
    verify_ok(3, 0);
    if (wq.size() > 256) begin
      check("bin0", 32'(wq[0][15:0]), 32'h0001);
      check("bin256", 32'(wq[256][15:0]), 32'h0001);
    end
    if (aq.size() == 4) begin
      check("addr0", aq[0], 32'h1800);
      check("addr3", aq[3], 32'h1E00);
    end

    // Random slots and hold lengths
    for (int t = 0; t < 2; t++) begin
      s = 4'($urandom);
      hold_cycles = $urandom_range(1, 2);
      start_load(s);
      wait_end(res, ec);
      check("rand_res", 32'(res), 32'd0);
      verify_ok(int'(s), 0);
    end

    // Level-held byte_available
    hold_cycles = 3;
    data_mode = 1;
    s = 4'($urandom);
    start_load(s);
    wait_end(res, ec);
    check("level_res", 32'(res), 32'd0);
    verify_ok(int'(s), 1);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    foreach (wq[i]) cnt[wq[i][25:24]]++;
    for (int i = 0; i < 4; i++) check("level_per_sector", 32'(cnt[i]), 32'd256);
    hold_cycles = 1;
    data_mode = 0;

    // Start while busy (slot 5 during sector 1 of a slot-2 load)
    start_load(4'd2);
    wait_writes(300);
    slot = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(res, ec);
    check("busy_res", 32'(res), 32'd0);
    verify_ok(2, 0);
    foreach (aq[i]) check("busy_range", 32'((aq[i] >= 32'h1000) && (aq[i] <= 32'h17FF)), 32'd1);

    // Timeout after byte 100 of sector 0
    stop_after = 100;
    start_load(4'd7);
    wait_end(res, ec);
    check("timeout_res", 32'(res), 32'd1);
    check("timeout_latency", 32'(((ec - last_byte_cyc) >= 1000) && ((ec - last_byte_cyc) <= 1002)), 32'd1);
    check("timeout_sd_rd", 32'(sd_rd), 32'd0);
    check("timeout_done", 32'(done_cnt), 32'd0);
    check("timeout_writes", 32'(wq.size()), 32'd50);
    check("timeout_loading", 32'(loading), 32'd0);
    repeat (20) @(negedge clk);
    check("error_sticky", 32'(error), 32'd1);
    model_abort = 1'b1;
    repeat (6) @(negedge clk);
    model_abort = 1'b0;
    stop_after = -1;

    // Recovery after error
    s = 4'($urandom);
    start_load(s);
    check("error_cleared", 32'(error), 32'd0);
    wait_end(res, ec);
    check("recover_res", 32'(res), 32'd0);
    verify_ok(int'(s), 0);

    // Reset mid-load, then a fresh slot-0 load
    start_load(4'd1);
    wait_writes(300);
    reset_n = 1'b0;
    model_abort = 1'b1;
    #1;
    check("mid_rst_sd_rd", 32'(sd_rd), 32'd0);
    check("mid_rst_sd_address", sd_address, 32'd0);
    check("mid_rst_haddr", 32'(haddr), 32'd0);
    check("mid_rst_hdata", 32'(hdata), 32'd0);
    check("mid_rst_hwe", 32'(hwe), 32'd0);
    check("mid_rst_loading", 32'(loading), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    model_abort = 1'b0;
    start_load(4'd0);
    wait_end(res, ec);
    check("fresh_res", 32'(res), 32'd0);
    verify_ok(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
